// File: rtl/sky130io_cfgseq_if.sv
// sky130io_cfgseq_if: mode-write request port (valid/ready with pad address and mode word)
interface sky130io_cfgseq_if #(
    parameter int AW = 3
) ();
    logic wr_valid;
    logic wr_ready;
    logic [AW-1:0] wr_addr;
    logic [9:0] wr_data;
    modport master(output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave(input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sky130io_cfgseq.sv
// sky130io_cfgseq: power-up and glitch-free mode-update sequencer for a bank of sky130 GPIO pads
module sky130io_cfgseq #(
    parameter int NPADS = 8,
    parameter int CFGW = 16,
    parameter int PWRCYC = 64,
    parameter int SETTLE = 16,
    parameter int HOLDCYC = 4,
    parameter logic [9:0] DEFMODE = 10'h300
) (
    input  logic clk,
    input  logic reset,
    input  logic sleep,
    sky130io_cfgseq_if.slave wr,
    output logic ready,
    output logic [NPADS*CFGW-1:0] cfg
);
    localparam int AW = NPADS > 1 ? $clog2(NPADS) : 1;
    localparam int MAXC = PWRCYC > SETTLE ? (PWRCYC > HOLDCYC ? PWRCYC : HOLDCYC)
                                          : (SETTLE > HOLDCYC ? SETTLE : HOLDCYC);
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {OFF, PWRWAIT, ENABLE, RUN, HOLD, UPDATE, RELEASE, SLEEP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr_q;
    logic [9:0] data_q;
    logic [9:0] mode [NPADS];
    logic [5:0] ctl, ctl_n;
    logic cap, we;
    always_comb begin
        state_n = state;
        cnt_n = '0;
        cap = 1'b0;
        case (state)
            OFF: state_n = PWRWAIT;
            PWRWAIT: if (cnt == CW'(PWRCYC - 1)) state_n = ENABLE; else cnt_n = cnt + 1'b1;
            ENABLE: if (cnt == CW'(SETTLE - 1)) state_n = RUN; else cnt_n = cnt + 1'b1;
            RUN: begin
                if (sleep) state_n = SLEEP;
                else if (wr.wr_valid) begin
                    state_n = HOLD;
                    cap = 1'b1;
                end
            end
            HOLD: if (cnt == CW'(HOLDCYC - 1)) state_n = UPDATE; else cnt_n = cnt + 1'b1;
            UPDATE: state_n = RELEASE;
            RELEASE: if (cnt == CW'(HOLDCYC - 1)) state_n = RUN; else cnt_n = cnt + 1'b1;
            SLEEP: if (!sleep) begin
                if (cnt == CW'(HOLDCYC - 1)) state_n = RUN; else cnt_n = cnt + 1'b1;
            end
            default: state_n = OFF;
        endcase
    end
    // Mode registers change on the UPDATE entry edge so the new word shows up alongside wr_ready.
    assign we = state == HOLD && state_n == UPDATE;
    assign ctl_n = state_n == OFF ? 6'b000000 : state_n == PWRWAIT ? 6'b100000 :
                   state_n == RUN ? 6'b111111 : 6'b111110;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
            cnt <= '0;
            ctl <= '0;
            ready <= 1'b0;
            wr.wr_ready <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            for (int p = 0; p < NPADS; p++) mode[p] <= DEFMODE;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ctl <= ctl_n;
            ready <= state_n == RUN;
            wr.wr_ready <= state_n == UPDATE;
            if (cap) begin
                addr_q <= wr.wr_addr;
                data_q <= wr.wr_data;
            end
            for (int p = 0; p < NPADS; p++) if (we && addr_q == AW'(p)) mode[p] <= data_q;
        end
    end
    genvar g;
    generate
        for (g = 0; g < NPADS; g++) begin : g_pad
            assign cfg[g*CFGW +: CFGW] = {mode[g], ctl};
        end
    endgenerate
endmodule

// File: tb/tb_sky130io_cfgseq.sv
// tb_sky130io_cfgseq: directed checks of power-up, mode writes, sleep and mid-op reset
module tb_sky130io_cfgseq;
    localparam int NP = 6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sleep = 1'b0;
    logic ready;
    logic [NP*16-1:0] cfg;
    logic [9:0] m [NP];
    int checks = 0;
    int errors = 0;
    sky130io_cfgseq_if #(.AW(3)) wr ();
    sky130io_cfgseq #(.NPADS(NP)) dut (.clk(clk), .reset(reset), .sleep(sleep), .wr(wr), .ready(ready), .cfg(cfg));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [NP*16-1:0] expcfg(input logic [5:0] c);
        logic [NP*16-1:0] r;
        for (int p = 0; p < NP; p++) r[p*16 +: 16] = {m[p], c};
        return r;
    endfunction
    task automatic test_reset;
        wr.wr_valid = 1'b0;
        wr.wr_addr = '0;
        wr.wr_data = '0;
        reset = 1'b1;
        for (int p = 0; p < NP; p++) m[p] = 10'h300;
        tick;
        tick;
        checks++; if (cfg !== expcfg(6'b000000)) begin errors++; $display("FAIL reset_cfg: got %h exp %h", cfg, expcfg(6'b000000)); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
        checks++; if (wr.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b exp 0", wr.wr_ready); end
    endtask
    task automatic test_powerup;
        logic [5:0] c;
        reset = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            tick;
            c = i <= 64 ? 6'b100000 : i <= 80 ? 6'b111110 : 6'b111111;
            checks++; if (cfg !== expcfg(c)) begin errors++; $display("FAIL powerup_cfg cyc %0d: got %h exp %h", i, cfg, expcfg(c)); end
            checks++; if (ready !== (i >= 81)) begin errors++; $display("FAIL powerup_ready cyc %0d: got %b exp %b", i, ready, i >= 81); end
        end
    endtask
    task automatic run_write(input logic [2:0] a, input logic [9:0] d, input string tag);
        logic [5:0] c;
        wr.wr_valid = 1'b1;
        wr.wr_addr = a;
        wr.wr_data = d;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i == 5 && a < NP) m[a] = d;
            c = i == 10 ? 6'b111111 : 6'b111110;
            checks++; if (cfg !== expcfg(c)) begin errors++; $display("FAIL %s_cfg cyc %0d: got %h exp %h", tag, i, cfg, expcfg(c)); end
            checks++; if (wr.wr_ready !== (i == 5)) begin errors++; $display("FAIL %s_wr_ready cyc %0d: got %b exp %b", tag, i, wr.wr_ready, i == 5); end
            checks++; if (ready !== (i == 10)) begin errors++; $display("FAIL %s_ready cyc %0d: got %b exp %b", tag, i, ready, i == 10); end
            if (i == 5) wr.wr_valid = 1'b0;
        end
    endtask
    task automatic test_mode_write;
        run_write(3'd3, 10'h2C5, "write3");
    endtask
    task automatic test_out_of_range;
        run_write(3'd7, 10'h3FF, "oor7");
        run_write(3'd6, 10'h001, "oor6");
    endtask
    task automatic test_back_to_back;
        run_write(3'd0, 10'h155, "b2b0");
        run_write(3'd5, 10'h0AA, "b2b5");
    endtask
    task automatic check_state(input logic [5:0] c, input logic r, input string tag, input int i);
        checks++; if (cfg !== expcfg(c)) begin errors++; $display("FAIL %s_cfg cyc %0d: got %h exp %h", tag, i, cfg, expcfg(c)); end
        checks++; if (ready !== r) begin errors++; $display("FAIL %s_ready cyc %0d: got %b exp %b", tag, i, ready, r); end
        checks++; if (wr.wr_ready !== 1'b0) begin errors++; $display("FAIL %s_wr_ready cyc %0d: got %b exp 0", tag, i, wr.wr_ready); end
    endtask
    task automatic test_sleep;
        sleep = 1'b1;
        for (int i = 1; i <= 20; i++) begin tick; check_state(6'b111110, 1'b0, "sleep", i); end
        sleep = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            check_state(i == 4 ? 6'b111111 : 6'b111110, i == 4, "wake", i);
        end
        sleep = 1'b1;
        for (int i = 1; i <= 3; i++) begin tick; check_state(6'b111110, 1'b0, "resleep", i); end
        sleep = 1'b0;
        for (int i = 1; i <= 2; i++) begin tick; check_state(6'b111110, 1'b0, "partwake", i); end
        sleep = 1'b1;
        tick;
        check_state(6'b111110, 1'b0, "reassert", 1);
        sleep = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            check_state(i == 4 ? 6'b111111 : 6'b111110, i == 4, "rewake", i);
        end
    endtask
    task automatic test_sleep_priority;
        sleep = 1'b1;
        wr.wr_valid = 1'b1;
        wr.wr_addr = 3'd1;
        wr.wr_data = 10'h0AB;
        for (int i = 1; i <= 5; i++) begin tick; check_state(6'b111110, 1'b0, "prio_sleep", i); end
        sleep = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            check_state(i == 4 ? 6'b111111 : 6'b111110, i == 4, "prio_wake", i);
        end
        run_write(3'd1, 10'h0AB, "prio_write");
    endtask
    task automatic test_reset_midop;
        wr.wr_valid = 1'b1;
        wr.wr_addr = 3'd0;
        wr.wr_data = 10'h1E7;
        tick;
        tick;
        check_state(6'b111110, 1'b0, "mid_hold", 2);
        reset = 1'b1;
        for (int p = 0; p < NP; p++) m[p] = 10'h300;
        for (int i = 1; i <= 6; i++) begin tick; check_state(6'b000000, 1'b0, "mid_reset", i); end
        wr.wr_valid = 1'b0;
        reset = 1'b0;
        tick;
        check_state(6'b100000, 1'b0, "mid_restart", 1);
    endtask
    initial begin
        test_reset;
        test_powerup;
        test_mode_write;
        test_out_of_range;
        test_back_to_back;
        test_sleep;
        test_sleep_priority;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
